// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : funct3 codes and FSM state encoding for load_store_unit | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_t;

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align : load lane extract/extend, store mask/data lane placement | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_mask,
  output logic [31:0] store_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    case (addr_lo)
      2'd0:    load_byte = mem_rd[7:0];
      2'd1:    load_byte = mem_rd[15:8];
      2'd2:    load_byte = mem_rd[23:16];
      default: load_byte = mem_rd[31:24];
    endcase
    load_half = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];

    case (funct3)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_BU:   load_data = {24'h0, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_HU:   load_data = {16'h0, load_half};
      F3_W:    load_data = mem_rd;
      default: load_data = 32'h0;
    endcase
  end

  // Data is replicated across lanes so the mask alone selects the target bytes.
  always_comb begin
    case (funct3)
      F3_B: begin
        store_mask = 32'h0000_00FF << {addr_lo, 3'b000};
        store_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        store_mask = addr_lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        store_data = {2{wdata[15:0]}};
      end
      default: begin
        store_mask = 32'hFFFF_FFFF;
        store_data = wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : RV32I byte/half/word access to word-only memory, RMW for SB/SH | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int XLEN      = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            misalign,
  output logic            fault_flag,
  output logic [XLEN-1:0] fault_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t  state, state_next;
  logic [29:0] hold_word;
  logic [31:0] hold_mask, hold_data, hold_old;
  logic [31:0] load_data, store_mask, store_data;
  logic        op_half, op_word, is_load, is_store, is_op;
  logic        bad_align, out_of_range, fault_now, req_ok, capture;

  lsu_lane_align u_lane_align (
    .funct3     (req_funct3),
    .addr_lo    (req_addr[1:0]),
    .mem_rd     (mem_rd),
    .wdata      (req_wdata),
    .load_data  (load_data),
    .store_mask (store_mask),
    .store_data (store_data)
  );

  always_comb begin
    op_half      = (req_funct3[1:0] == 2'b01);
    op_word      = (req_funct3[1:0] == 2'b10);
    is_load      = !req_we && (req_funct3 == F3_B  || req_funct3 == F3_H || req_funct3 == F3_W ||
                               req_funct3 == F3_BU || req_funct3 == F3_HU);
    is_store     = req_we && (req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W);
    is_op        = req_valid && (is_load || is_store);
    bad_align    = (op_half && req_addr[0]) || (op_word && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    fault_now    = is_op && (bad_align || out_of_range);
    req_ok       = is_op && !(bad_align || out_of_range);
  end

  // Outputs are held quiet during reset so a pending request cannot stall or write.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    misalign   = 1'b0;
    mem_we     = 1'b0;
    mem_a      = {req_addr[31:2], 2'b00};
    mem_wd     = req_wdata;
    rdata      = 32'h0;
    capture    = 1'b0;
    if (RST) begin
      case (state)
        IDLE: begin
          misalign = fault_now;
          if (req_ok && is_load) begin
            rdata = load_data;
          end else if (req_ok && op_word) begin
            mem_we = 1'b1;
          end else if (req_ok) begin
            stall      = 1'b1;
            capture    = 1'b1;
            state_next = MERGE;
          end
        end
        MERGE: begin
          mem_a      = {hold_word, 2'b00};
          mem_we     = 1'b1;
          mem_wd     = (hold_old & ~hold_mask) | (hold_data & hold_mask);
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      hold_word  <= 30'h0;
      hold_mask  <= 32'h0;
      hold_data  <= 32'h0;
      hold_old   <= 32'h0;
      fault_flag <= 1'b0;
      fault_addr <= 32'h0;
    end else begin
      state <= state_next;
      if (capture) begin
        hold_word <= req_addr[31:2];
        hold_mask <= store_mask;
        hold_data <= store_data;
        hold_old  <= mem_rd;
      end
      if (misalign && !fault_flag) begin
        fault_flag <= 1'b1;
        fault_addr <= req_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench for load_store_unit | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk, rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata, fault_addr, mem_a, mem_wd, mem_rd;
  logic        stall, misalign, fault_flag, mem_we;

  logic [31:0] mem [0:63];
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] exp_rdata;
  } vec_t;

  load_store_unit #(.MEM_WORDS(64), .XLEN(32)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rdata      (rdata),
    .stall      (stall),
    .misalign   (misalign),
    .fault_flag (fault_flag),
    .fault_addr (fault_addr),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = (mem_a[31:2] < 30'd64) ? mem[mem_a[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && (mem_a[31:2] < 30'd64)) mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic sw_word(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, SW, a, d);
    @(negedge clk);
    check("preload_sw_we", {31'h0, mem_we}, 32'h1);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    vecs[0] = '{LB,     32'h0D,  32'hFFFF_FFAA};
    vecs[1] = '{LBU,    32'h0D,  32'h0000_00AA};
    vecs[2] = '{LHU,    32'h0E,  32'h0000_8899};
    vecs[3] = '{LH,     32'h0E,  32'hFFFF_8899};
    vecs[4] = '{LW,     32'h0C,  32'h8899_AABB};
    vecs[5] = '{LB,     32'h0C,  32'hFFFF_FFBB};
    vecs[6] = '{LBU,    32'h0F,  32'h0000_0088};
    vecs[7] = '{LH,     32'h0C,  32'hFFFF_AABB};
    vecs[8] = '{3'b011, 32'h0C,  32'h0000_0000};
    vecs[9] = '{3'b110, 32'h400, 32'h0000_0000};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_mem_we", {31'h0, mem_we}, 32'h0);
    check("reset_fault_flag", {31'h0, fault_flag}, 32'h0);
    check("reset_fault_addr", fault_addr, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    sw_word(32'h00, 32'h0BAD_F00D);
    sw_word(32'h08, 32'hDEAD_BEEF);
    sw_word(32'h0C, 32'h8899_AABB);
    sw_word(32'h14, 32'h1122_3344);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, vecs[i].f3, vecs[i].addr, 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_misalign", i), {31'h0, misalign}, 32'h0);
      check($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
      check($sformatf("vec%0d_mem_we", i), {31'h0, mem_we}, 32'h0);
      check($sformatf("vec%0d_mem_a", i), mem_a, vecs[i].addr & 32'hFFFF_FFFC);
      next_cycle();
    end

    // SB into lane 1 of word 5
    drive(1'b1, 1'b1, SB, 32'h15, 32'h0000_00EE);
    @(negedge clk);
    check("sb_c1_stall", {31'h0, stall}, 32'h1);
    check("sb_c1_mem_we", {31'h0, mem_we}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("sb_c2_stall", {31'h0, stall}, 32'h0);
    check("sb_c2_mem_we", {31'h0, mem_we}, 32'h1);
    check("sb_c2_mem_a", mem_a, 32'h14);
    check("sb_c2_mem_wd", mem_wd, 32'h1122_EE44);
    next_cycle();
    drive(1'b1, 1'b0, LW, 32'h14, 32'h0);
    @(negedge clk);
    check("sb_readback", rdata, 32'h1122_EE44);
    next_cycle();

    // SH upper half, followed immediately by SW
    sw_word(32'h14, 32'h1122_3344);
    drive(1'b1, 1'b1, SH, 32'h16, 32'h0000_CAFE);
    @(negedge clk);
    check("sh_c1_stall", {31'h0, stall}, 32'h1);
    check("sh_c1_mem_we", {31'h0, mem_we}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("sh_c2_mem_we", {31'h0, mem_we}, 32'h1);
    check("sh_c2_mem_wd", mem_wd, 32'hCAFE_3344);
    check("sh_c2_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, SW, 32'h18, 32'h5);
    @(negedge clk);
    check("sw_after_mem_we", {31'h0, mem_we}, 32'h1);
    check("sw_after_mem_a", mem_a, 32'h18);
    check("sw_after_mem_wd", mem_wd, 32'h5);
    check("sw_after_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, LW, 32'h14, 32'h0);
    @(negedge clk);
    check("sh_readback", rdata, 32'hCAFE_3344);
    next_cycle();

    // Faults: first one is captured, later ones leave fault_addr alone
    drive(1'b1, 1'b1, SW, 32'h22, 32'h1234);
    @(negedge clk);
    check("sw_mis_misalign", {31'h0, misalign}, 32'h1);
    check("sw_mis_mem_we", {31'h0, mem_we}, 32'h0);
    check("sw_mis_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    check("fault_flag_set", {31'h0, fault_flag}, 32'h1);
    check("fault_addr_first", fault_addr, 32'h22);
    drive(1'b1, 1'b0, LW, 32'h400, 32'h0);
    @(negedge clk);
    check("lw_oor_misalign", {31'h0, misalign}, 32'h1);
    check("lw_oor_rdata", rdata, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, LH, 32'h0F, 32'h0);
    @(negedge clk);
    check("lh_odd_misalign", {31'h0, misalign}, 32'h1);
    next_cycle();
    check("fault_addr_kept", fault_addr, 32'h22);

    // Illegal store funct3 is a no-op
    drive(1'b1, 1'b1, 3'b011, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    check("noop_mem_we", {31'h0, mem_we}, 32'h0);
    check("noop_misalign", {31'h0, misalign}, 32'h0);
    check("noop_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, LW, 32'h0, 32'h0);
    @(negedge clk);
    check("noop_mem_unchanged", rdata, 32'h0BAD_F00D);
    next_cycle();

    // Reset during MERGE abandons the write
    drive(1'b1, 1'b1, SB, 32'h08, 32'h0000_0011);
    @(negedge clk);
    check("rst_sb_c1_stall", {31'h0, stall}, 32'h1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_merge_stall", {31'h0, stall}, 32'h0);
    check("rst_merge_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_merge_fault_flag", {31'h0, fault_flag}, 32'h0);
    check("rst_merge_fault_addr", fault_addr, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, LW, 32'h08, 32'h0);
    @(negedge clk);
    check("rst_word2_kept", rdata, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
